hazard_control_unit: RTL and testbench

HAZARD_CONTROL_UNIT -- requirements
Module: hazard_control_unit

---
 rtl/riscv_pkg.sv | 38 +++
 rtl/load_use_detect.sv | 21 ++
 rtl/hazard_control_unit.sv | 175 +++++++++++++++++
 tb/tb_hazard_control_unit.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// Shared RISC-V pipeline definitions: hazard FSM encoding, control-bundle
// payload, NOP encoding and register-index constants.
package riscv_pkg;

    localparam int unsigned XLEN        = 32;
    localparam int unsigned REG_IDX_W   = 5;
    localparam int unsigned STALL_CNT_W = 3;
    localparam int unsigned DRAIN_CNT_W = 2;
    // ID, EX and MEM must retire before the pipeline is frozen
    localparam int unsigned DRAIN_CYCLES = 3;

    localparam logic [XLEN-1:0]      NOP_INSN = 32'h0000_0013;  // addi x0,x0,0
    localparam logic [REG_IDX_W-1:0] REG_X0   = 5'd0;

    typedef enum logic [1:0] {
        ST_RUN        = 2'd0,
        ST_LOAD_STALL = 2'd1,
        ST_DRAIN      = 2'd2,
        ST_HALTED     = 2'd3
    } hcu_state_e;

    // Pipeline control bundle driven by the hazard unit every cycle
    typedef struct packed {
        logic pc_write;
        logic if_id_write;
        logic if_id_flush;
        logic id_ex_flush;
        logic pc_sel_redirect;
    } hcu_ctrl_t;

    localparam hcu_ctrl_t CTRL_RUN      = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    localparam hcu_ctrl_t CTRL_REDIRECT = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    localparam hcu_ctrl_t CTRL_STALL    = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    // Freeze fetch, keep ID/EX/MEM flowing so they retire
    localparam hcu_ctrl_t CTRL_DRAIN    = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    localparam hcu_ctrl_t CTRL_FROZEN   = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0};

endpackage

// File: rtl/load_use_detect.sv
// Combinational load-use hazard detector.
// Ports: id_rs1_i/id_rs2_i + id_use_rs1_i/id_use_rs2_i (ID sources),
//        ex_rd_i/ex_mem_read_i (EX load destination), hazard_o.
module load_use_detect
    import riscv_pkg::*;
(
    input  logic [REG_IDX_W-1:0] id_rs1_i,
    input  logic [REG_IDX_W-1:0] id_rs2_i,
    input  logic                 id_use_rs1_i,
    input  logic                 id_use_rs2_i,
    input  logic [REG_IDX_W-1:0] ex_rd_i,
    input  logic                 ex_mem_read_i,
    output logic                 hazard_o
);

    // x0 is never a real dependency
    assign hazard_o = ex_mem_read_i && (ex_rd_i != REG_X0) &&
                      ((id_use_rs1_i && (id_rs1_i == ex_rd_i)) ||
                       (id_use_rs2_i && (id_rs2_i == ex_rd_i)));

endmodule

// File: rtl/hazard_control_unit.sv
// Pipeline hazard controller: load-use stalls, EX redirects, external halt
// with drain, self-loop halt, and saturating stall/flush event counters.
// Ports: clk, rst (sync, active-low); ID/EX hazard and redirect inputs;
//        halt_req; pipeline enables/flushes, pc_sel_redirect (same-cycle);
//        halted, halt_cause, stall_count, flush_count (registered).
module hazard_control_unit
    import riscv_pkg::*;
#(
    parameter int unsigned LOAD_STALL_CYCLES = 1,
    parameter int unsigned CNT_W             = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [REG_IDX_W-1:0] id_rs1,
    input  logic [REG_IDX_W-1:0] id_rs2,
    input  logic                 id_use_rs1,
    input  logic                 id_use_rs2,
    input  logic [REG_IDX_W-1:0] ex_rd,
    input  logic                 ex_mem_read,
    input  logic                 ex_redirect,
    input  logic [XLEN-1:0]      ex_pc,
    input  logic [XLEN-1:0]      ex_target,
    input  logic                 halt_req,
    output logic                 pc_write,
    output logic                 if_id_write,
    output logic                 if_id_flush,
    output logic                 id_ex_flush,
    output logic                 pc_sel_redirect,
    output logic                 halted,
    output logic                 halt_cause,
    output logic [CNT_W-1:0]     stall_count,
    output logic [CNT_W-1:0]     flush_count
);

    localparam logic [STALL_CNT_W-1:0] STALL_LOAD = STALL_CNT_W'(LOAD_STALL_CYCLES - 1);
    localparam logic [DRAIN_CNT_W-1:0] DRAIN_LOAD = DRAIN_CNT_W'(DRAIN_CYCLES - 1);

    hcu_state_e             state_q, state_d;
    logic [STALL_CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [DRAIN_CNT_W-1:0] drain_cnt_q, drain_cnt_d;
    logic                   halt_cause_q, halt_cause_d;
    logic                   halted_q;
    logic [CNT_W-1:0]       stall_count_q, stall_count_d;
    logic [CNT_W-1:0]       flush_count_q, flush_count_d;
    logic                   hazard;
    logic                   stall_evt;
    logic                   flush_evt;
    hcu_ctrl_t              ctrl;

    load_use_detect u_detect (
        .id_rs1_i      (id_rs1),
        .id_rs2_i      (id_rs2),
        .id_use_rs1_i  (id_use_rs1),
        .id_use_rs2_i  (id_use_rs2),
        .ex_rd_i       (ex_rd),
        .ex_mem_read_i (ex_mem_read),
        .hazard_o      (hazard)
    );

    // State and counter registers
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q       <= ST_RUN;
            stall_cnt_q   <= '0;
            drain_cnt_q   <= '0;
            halt_cause_q  <= 1'b0;
            halted_q      <= 1'b0;
            stall_count_q <= '0;
            flush_count_q <= '0;
        end else begin
            state_q       <= state_d;
            stall_cnt_q   <= stall_cnt_d;
            drain_cnt_q   <= drain_cnt_d;
            halt_cause_q  <= halt_cause_d;
            halted_q      <= (state_d == ST_HALTED);
            stall_count_q <= stall_count_d;
            flush_count_q <= flush_count_d;
        end
    end

    // Next-state and pipeline control
    always_comb begin
        state_d      = state_q;
        stall_cnt_d  = stall_cnt_q;
        drain_cnt_d  = drain_cnt_q;
        halt_cause_d = halt_cause_q;
        ctrl         = CTRL_RUN;
        stall_evt    = 1'b0;
        flush_evt    = 1'b0;
        case (state_q)
            ST_RUN: begin
                if (halt_req) begin
                    ctrl        = CTRL_DRAIN;
                    state_d     = ST_DRAIN;
                    drain_cnt_d = DRAIN_LOAD;
                    stall_cnt_d = '0;
                end else if (ex_redirect) begin
                    // older EX branch wins over a younger load-use hazard
                    ctrl      = CTRL_REDIRECT;
                    flush_evt = 1'b1;
                    if (ex_target == ex_pc) begin
                        state_d      = ST_HALTED;
                        halt_cause_d = 1'b1;
                    end
                end else if (hazard) begin
                    ctrl        = CTRL_STALL;
                    stall_evt   = 1'b1;
                    stall_cnt_d = STALL_LOAD;
                    if (STALL_LOAD != '0) begin
                        state_d = ST_LOAD_STALL;
                    end
                end
            end
            ST_LOAD_STALL: begin
                if (halt_req) begin
                    ctrl        = CTRL_DRAIN;
                    state_d     = ST_DRAIN;
                    drain_cnt_d = DRAIN_LOAD;
                    stall_cnt_d = '0;
                end else begin
                    ctrl        = CTRL_STALL;
                    stall_evt   = 1'b1;
                    stall_cnt_d = stall_cnt_q - STALL_CNT_W'(1);
                    if (stall_cnt_q <= STALL_CNT_W'(1)) begin
                        state_d = ST_RUN;
                    end
                end
            end
            ST_DRAIN: begin
                ctrl = CTRL_DRAIN;
                if (drain_cnt_q == '0) begin
                    state_d      = ST_HALTED;
                    halt_cause_d = 1'b0;
                end else begin
                    drain_cnt_d = drain_cnt_q - DRAIN_CNT_W'(1);
                end
            end
            ST_HALTED: begin
                ctrl = CTRL_FROZEN;
                // a self-loop halt is sticky until reset
                if (!halt_cause_q && !halt_req) begin
                    state_d = ST_RUN;
                end
            end
            default: begin
                state_d = ST_RUN;
            end
        endcase
    end

    // Saturating event counters
    always_comb begin
        stall_count_d = stall_count_q;
        flush_count_d = flush_count_q;
        if (stall_evt && (stall_count_q != {CNT_W{1'b1}})) begin
            stall_count_d = stall_count_q + CNT_W'(1);
        end
        if (flush_evt && (flush_count_q != {CNT_W{1'b1}})) begin
            flush_count_d = flush_count_q + CNT_W'(1);
        end
    end

    // Reset holds the pipeline frozen with both stages flushed
    assign pc_write        = rst ? ctrl.pc_write        : 1'b0;
    assign if_id_write     = rst ? ctrl.if_id_write     : 1'b0;
    assign if_id_flush     = rst ? ctrl.if_id_flush     : 1'b1;
    assign id_ex_flush     = rst ? ctrl.id_ex_flush     : 1'b1;
    assign pc_sel_redirect = rst ? ctrl.pc_sel_redirect : 1'b0;

    assign halted      = halted_q;
    assign halt_cause  = halt_cause_q;
    assign stall_count = stall_count_q;
    assign flush_count = flush_count_q;

endmodule

// File: tb/tb_hazard_control_unit.sv
// Directed bench for hazard_control_unit: three instances (default, 3-cycle
// load stall, 4-bit counters) share one stimulus stream.
module tb_hazard_control_unit;
    import riscv_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  id_rs1, id_rs2, ex_rd;
    logic        id_use_rs1, id_use_rs2, ex_mem_read, ex_redirect, halt_req;
    logic [31:0] ex_pc, ex_target;

    logic        a_pcw, a_ifw, a_iff, a_ixf, a_sel, a_halted, a_cause;
    logic [15:0] a_stall, a_flush;
    logic        b_pcw, b_ifw, b_iff, b_ixf, b_sel, b_halted, b_cause;
    logic [15:0] b_stall, b_flush;
    logic        c_pcw, c_ifw, c_iff, c_ixf, c_sel, c_halted, c_cause;
    logic [3:0]  c_stall, c_flush;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    hazard_control_unit u_dut_a (
        .clk(clk), .rst(rst), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .ex_rd(ex_rd),
        .ex_mem_read(ex_mem_read), .ex_redirect(ex_redirect), .ex_pc(ex_pc),
        .ex_target(ex_target), .halt_req(halt_req), .pc_write(a_pcw),
        .if_id_write(a_ifw), .if_id_flush(a_iff), .id_ex_flush(a_ixf),
        .pc_sel_redirect(a_sel), .halted(a_halted), .halt_cause(a_cause),
        .stall_count(a_stall), .flush_count(a_flush)
    );

    hazard_control_unit #(.LOAD_STALL_CYCLES(3)) u_dut_b (
        .clk(clk), .rst(rst), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .ex_rd(ex_rd),
        .ex_mem_read(ex_mem_read), .ex_redirect(ex_redirect), .ex_pc(ex_pc),
        .ex_target(ex_target), .halt_req(halt_req), .pc_write(b_pcw),
        .if_id_write(b_ifw), .if_id_flush(b_iff), .id_ex_flush(b_ixf),
        .pc_sel_redirect(b_sel), .halted(b_halted), .halt_cause(b_cause),
        .stall_count(b_stall), .flush_count(b_flush)
    );

    hazard_control_unit #(.CNT_W(4)) u_dut_c (
        .clk(clk), .rst(rst), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .ex_rd(ex_rd),
        .ex_mem_read(ex_mem_read), .ex_redirect(ex_redirect), .ex_pc(ex_pc),
        .ex_target(ex_target), .halt_req(halt_req), .pc_write(c_pcw),
        .if_id_write(c_ifw), .if_id_flush(c_iff), .id_ex_flush(c_ixf),
        .pc_sel_redirect(c_sel), .halted(c_halted), .halt_cause(c_cause),
        .stall_count(c_stall), .flush_count(c_flush)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Advance one clock; land 1 time unit after the rising edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        id_rs1 = 5'd0; id_rs2 = 5'd0; id_use_rs1 = 1'b0; id_use_rs2 = 1'b0;
        ex_rd = 5'd0; ex_mem_read = 1'b0; ex_redirect = 1'b0; halt_req = 1'b0;
        ex_pc = 32'h0; ex_target = 32'h4;
    endtask

    // lw x19,0(x10) in EX, add x3,x19,x2 in ID
    task automatic load_use();
        ex_mem_read = 1'b1; ex_rd = 5'd19;
        id_rs1 = 5'd19; id_use_rs1 = 1'b1; id_rs2 = 5'd2; id_use_rs2 = 1'b1;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        idle();
        step();
        step();
        rst = 1'b1;
    endtask

    initial begin
        // reset state
        rst = 1'b0;
        idle();
        step();
        step();
        #1;
        check("rst_pc_write", a_pcw, 1'b0);
        check("rst_if_id_write", a_ifw, 1'b0);
        check("rst_if_id_flush", a_iff, 1'b1);
        check("rst_id_ex_flush", a_ixf, 1'b1);
        check("rst_halted", a_halted, 1'b0);
        check("rst_cause", a_cause, 1'b0);
        check("rst_stall_count", a_stall, 16'd0);
        check("rst_flush_count", a_flush, 16'd0);
        rst = 1'b1;
        step();

        // plain RUN
        #1;
        check("run_pc_write", a_pcw, 1'b1);
        check("run_if_id_write", a_ifw, 1'b1);
        check("run_if_id_flush", a_iff, 1'b0);
        check("run_id_ex_flush", a_ixf, 1'b0);
        check("run_sel", a_sel, 1'b0);

        // non-hazard patterns (no clock edge crossed)
        load_use(); ex_rd = 5'd0; id_rs1 = 5'd0; #1;
        check("x0_no_hazard", a_pcw, 1'b1);
        load_use(); id_use_rs1 = 1'b0; #1;
        check("unused_rs1_no_hazard", a_ixf, 1'b0);
        load_use(); ex_mem_read = 1'b0; #1;
        check("not_load_no_hazard", a_pcw, 1'b1);
        load_use(); id_rs1 = 5'd4; id_rs2 = 5'd19; #1;
        check("rs2_hazard", a_pcw, 1'b0);
        idle();

        // single-cycle load-use stall
        step();
        load_use(); #1;
        check("lu_pc_write", a_pcw, 1'b0);
        check("lu_if_id_write", a_ifw, 1'b0);
        check("lu_id_ex_flush", a_ixf, 1'b1);
        check("lu_sel", a_sel, 1'b0);
        step();
        idle(); #1;
        check("lu_done_pc_write", a_pcw, 1'b1);
        check("lu_stall_count", a_stall, 16'd1);
        check("lu3_still_stalled", b_pcw, 1'b0);
        check("lu3_id_ex_flush", b_ixf, 1'b1);
        step();
        #1;
        check("lu3_second_ls", b_pcw, 1'b0);
        step();
        #1;
        check("lu3_back_to_run", b_pcw, 1'b1);
        check("lu3_stall_count", b_stall, 16'd3);
        check("lu_stall_count_held", a_stall, 16'd1);

        // taken beq with a simultaneous hazard
        do_reset();
        load_use(); ex_redirect = 1'b1; ex_pc = 32'h60; ex_target = 32'h6C; #1;
        check("br_sel", a_sel, 1'b1);
        check("br_if_id_flush", a_iff, 1'b1);
        check("br_id_ex_flush", a_ixf, 1'b1);
        check("br_pc_write", a_pcw, 1'b1);
        step();
        idle(); #1;
        check("br_flush_count", a_flush, 16'd1);
        check("br_stall_count", a_stall, 16'd0);
        check("br3_no_stall", b_pcw, 1'b1);

        // external halt held for 10 cycles, redirect attempted during drain
        do_reset();
        for (int i = 0; i < 10; i++) begin
            idle();
            halt_req = 1'b1;
            if (i == 1) begin
                ex_redirect = 1'b1; ex_pc = 32'h20; ex_target = 32'h40;
            end
            #1;
            check($sformatf("halt_pc_write_%0d", i), a_pcw, 1'b0);
            check($sformatf("halt_halted_%0d", i), a_halted, (i >= 4) ? 1'b1 : 1'b0);
            if (i == 0) check("halt_entry_if_id_flush", a_iff, 1'b1);
            if (i == 1) check("drain_no_redirect", a_sel, 1'b0);
            if (i == 5) begin
                check("halted_if_id_write", a_ifw, 1'b0);
                check("halted_id_ex_flush", a_ixf, 1'b1);
                check("halted_cause_ext", a_cause, 1'b0);
            end
            step();
        end
        idle(); #1;
        check("halt_release_still_halted", a_halted, 1'b1);
        step();
        #1;
        check("halt_release_run", a_pcw, 1'b1);
        check("halt_release_halted", a_halted, 1'b0);
        check("drain_flush_count", a_flush, 16'd0);

        // jal x0,0 self-loop
        do_reset();
        ex_redirect = 1'b1; ex_pc = 32'hA8; ex_target = 32'hA8; #1;
        check("loop_sel", a_sel, 1'b1);
        step();
        idle(); #1;
        check("loop_halted", a_halted, 1'b1);
        check("loop_cause", a_cause, 1'b1);
        check("loop_flush_count", a_flush, 16'd1);
        halt_req = 1'b1;
        step();
        idle();
        step();
        step();
        #1;
        check("loop_sticky_halted", a_halted, 1'b1);
        check("loop_sticky_pc_write", a_pcw, 1'b0);
        rst = 1'b0; #1;
        check("loop_rst_id_ex_flush", a_ixf, 1'b1);
        step();
        #1;
        check("loop_rst_halted", a_halted, 1'b0);
        check("loop_rst_cause", a_cause, 1'b0);
        rst = 1'b1;
        step();
        #1;
        check("loop_rst_run", a_pcw, 1'b1);

        // 3-cycle stall aborted by reset on its second cycle
        do_reset();
        load_use(); #1;
        check("ab_first_stall", b_pcw, 1'b0);
        step();
        idle(); #1;
        check("ab_second_stall", b_pcw, 1'b0);
        check("ab_stall_count_mid", b_stall, 16'd1);
        rst = 1'b0;
        step();
        rst = 1'b1; #1;
        check("ab_run", b_pcw, 1'b1);
        check("ab_stall_count", b_stall, 16'd0);
        check("ab_flush_count", b_flush, 16'd0);

        // 20 redirects against a 4-bit counter
        do_reset();
        for (int i = 0; i < 20; i++) begin
            ex_redirect = 1'b1; ex_pc = 32'h100; ex_target = 32'h200;
            step();
            if (i == 14) begin
                #1;
                check("sat_flush_at_15", c_flush, 4'd15);
            end
        end
        idle(); #1;
        check("sat_flush_held", c_flush, 4'd15);
        check("wide_flush_20", a_flush, 16'd20);
        check("sat_stall_zero", c_stall, 4'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
